// File: rtl/dma_chan_arbiter.sv
// ============================================================================
// Module      : dma_chan_arbiter
// Description : Round-robin arbiter sharing one DMA engine among NUM_CH
//               channels. Optional watchdog via `DMA_ARB_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_chan_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CH-1:0]                ch_req_i,
    output logic [NUM_CH-1:0]                ch_req_ack_o,
    input  logic [NUM_CH*12-1:0]             ch_bytes_i,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] ch_rd_addr_i,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] ch_wr_addr_i,
    input  logic [NUM_CH*8-1:0]              ch_rd_cfg_i,
    input  logic [NUM_CH*8-1:0]              ch_wr_cfg_i,
    output logic [NUM_CH-1:0]                ch_rd_beat_o,
    output logic [NUM_CH-1:0]                ch_wr_beat_o,
    output logic [NUM_CH-1:0]                ch_rd_done_o,
    output logic [NUM_CH-1:0]                ch_wr_done_o,
    output logic [NUM_CH-1:0]                grant_o,
    output logic                             busy_o,
    output logic                             timeout_o,
    output logic                             dma_req_o,
    input  logic                             dma_req_ack_i,
    input  logic                             dma_rdy_i,
    output logic [11:0]                      dma_bytes_o,
    output logic [AXI_ADDR_WIDTH-1:0]        dma_rd_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]        dma_wr_addr_o,
    output logic [2:0]                       dma_rd_size_o,
    output logic [2:0]                       dma_wr_size_o,
    output logic [3:0]                       dma_rd_burst_o,
    output logic [3:0]                       dma_wr_burst_o,
    output logic                             dma_rd_inc_o,
    output logic                             dma_wr_inc_o,
    input  logic                             dma_rd_beat_i,
    input  logic                             dma_wr_beat_i,
    input  logic                             dma_rd_done_i,
    input  logic                             dma_wr_done_i
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int SUM_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_CH-1:0]   r_grant;
    logic [PTR_W-1:0]    r_gidx;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic                r_rd_seen;
    logic                r_wr_seen;

    logic [PTR_W-1:0]    w_pick_idx;
    logic [NUM_CH-1:0]   w_pick_oh;
    logic [SUM_W-1:0]    w_sum;
    logic                w_g_req;
    logic                w_ack_fire;
    logic                w_finish;
    logic                w_in_busy;
    logic                w_wdog_fire;
    logic [PTR_W-1:0]    w_next_ptr;

    if (NUM_CH < 2 || NUM_CH > 8 || WDOG_CYCLES < 1) begin : g_param_check
        $error("dma_chan_arbiter: parameter out of range");
    end

    // Descending scan so the smallest offset from r_rr_ptr wins.
    always_comb begin
        w_pick_idx = '0;
        w_sum      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_CH)) begin
                w_sum = w_sum - SUM_W'(NUM_CH);
            end
            if (ch_req_i[w_sum[PTR_W-1:0]]) begin
                w_pick_idx = w_sum[PTR_W-1:0];
            end
        end
        w_pick_oh             = '0;
        w_pick_oh[w_pick_idx] = 1'b1;
    end

    assign w_g_req    = |(ch_req_i & r_grant);
    assign w_in_busy  = (r_state == S_BUSY);
    assign w_next_ptr = (r_gidx == PTR_W'(NUM_CH - 1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_fire  = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|ch_req_i && dma_rdy_i) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_g_req && dma_req_ack_i) begin
                    w_ack_fire  = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (!w_g_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (((r_rd_seen || dma_rd_done_i) && (r_wr_seen || dma_wr_done_i))
                    || w_wdog_fire) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_REQ) begin
                r_grant <= w_pick_oh;
                r_gidx  <= w_pick_idx;
            end
            if (w_ack_fire) begin
                r_rd_seen <= 1'b0;
                r_wr_seen <= 1'b0;
            end else if (w_in_busy) begin
                if (dma_rd_done_i) r_rd_seen <= 1'b1;
                if (dma_wr_done_i) r_wr_seen <= 1'b1;
            end
            // A dropped request leaves the pointer untouched; only completion advances it.
            if (r_state == S_REQ && w_state_nxt == S_IDLE) begin
                r_grant <= '0;
            end
            if (w_finish) begin
                r_grant  <= '0;
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

`ifdef DMA_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_ack_fire) begin
            r_wdog <= '0;
        end else if (w_in_busy) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Fires in the WDOG_CYCLES-th cycle spent in BUSY.
    assign w_wdog_fire = w_in_busy && (r_wdog == WD_W'(WDOG_CYCLES - 1));
`else
    assign w_wdog_fire = 1'b0;
`endif

    assign timeout_o    = w_wdog_fire;
    assign busy_o       = (r_state != S_IDLE);
    assign grant_o      = busy_o ? r_grant : '0;
    assign dma_req_o    = (r_state == S_REQ) && w_g_req;
    assign ch_req_ack_o = r_grant & {NUM_CH{w_ack_fire}};

    assign ch_rd_beat_o = r_grant & {NUM_CH{w_in_busy & dma_rd_beat_i}};
    assign ch_wr_beat_o = r_grant & {NUM_CH{w_in_busy & dma_wr_beat_i}};
    assign ch_rd_done_o = r_grant & {NUM_CH{w_in_busy & (dma_rd_done_i | w_wdog_fire)}};
    assign ch_wr_done_o = r_grant & {NUM_CH{w_in_busy & (dma_wr_done_i | w_wdog_fire)}};

    always_comb begin
        dma_bytes_o    = '0;
        dma_rd_addr_o  = '0;
        dma_wr_addr_o  = '0;
        dma_rd_size_o  = '0;
        dma_wr_size_o  = '0;
        dma_rd_burst_o = '0;
        dma_wr_burst_o = '0;
        dma_rd_inc_o   = 1'b0;
        dma_wr_inc_o   = 1'b0;
        if (r_state != S_IDLE) begin
            dma_bytes_o    = ch_bytes_i[r_gidx*12 +: 12];
            dma_rd_addr_o  = ch_rd_addr_i[r_gidx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            dma_wr_addr_o  = ch_wr_addr_i[r_gidx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            dma_rd_size_o  = ch_rd_cfg_i[r_gidx*8 +: 3];
            dma_wr_size_o  = ch_wr_cfg_i[r_gidx*8 +: 3];
            dma_rd_burst_o = ch_rd_cfg_i[r_gidx*8+3 +: 4];
            dma_wr_burst_o = ch_wr_cfg_i[r_gidx*8+3 +: 4];
            dma_rd_inc_o   = ch_rd_cfg_i[r_gidx*8+7];
            dma_wr_inc_o   = ch_wr_cfg_i[r_gidx*8+7];
        end
    end

endmodule

`default_nettype wire
